// File: rtl/dcache_axi_bridge_if.sv
// Single-beat AXI3/AXI4 read and write channel bundle used by dcache_axi_bridge.
// The master modport is the bridge side; the slave modport is the memory/interconnect side.
interface dcache_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/dcache_axi_bridge.sv
// Turns each dcache sram-like request into one single-beat AXI transaction, one at a time.
// Optional macro WRITE_EARLY_ACK_EN: acknowledge writes once AW and W are both accepted.
module dcache_axi_bridge #(
   parameter logic [3:0]  AXI_ID    = 4'd1,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 data_req,
   input  logic                 data_wr,
   input  logic [1:0]           data_size,
   input  logic [31:0]          data_addr,
   input  logic [31:0]          data_wdata,
   input  logic [3:0]           data_wstrb,
   output logic [31:0]          data_rdata,
   output logic                 data_addr_ok,
   output logic                 data_data_ok,
   dcache_axi_bridge_if.master  axi,
   output logic [ERR_CNT_W-1:0] err_cnt
);

`ifdef WRITE_EARLY_ACK_EN
   localparam bit EarlyAck = 1'b1;
`else
   localparam bit EarlyAck = 1'b0;
`endif

   typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWrAw, StWrB} state_e;

   state_e                state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic [1:0]            size_q, size_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  data_ok_q, data_ok_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic                  resp_err;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         data_ok_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         data_ok_q <= data_ok_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      data_ok_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (data_addr_ok) begin
               addr_d    = data_addr;
               size_d    = data_size;
               wdata_d   = data_wdata;
               wstrb_d   = data_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = data_wr ? StWrAw : StRdA;
            end
         end
         StRdA: begin
            if (axi.arready) state_d = StRdD;
         end
         StRdD: begin
            if (axi.rvalid) begin
               rdata_d   = axi.rdata;
               data_ok_d = 1'b1;
               state_d   = StIdle;
            end
         end
         StWrAw: begin
            // AW and W complete independently, possibly in the same cycle.
            aw_done_d = aw_done_q | (axi.awvalid & axi.awready);
            w_done_d  = w_done_q | (axi.wvalid & axi.wready);
            if (aw_done_d && w_done_d) begin
               state_d   = StWrB;
               data_ok_d = EarlyAck;
            end
         end
         StWrB: begin
            if (axi.bvalid) begin
               state_d   = StIdle;
               data_ok_d = ~EarlyAck;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign resp_err = (axi.rvalid & axi.rready & (axi.rresp != 2'b00)) |
                     (axi.bvalid & axi.bready & (axi.bresp != 2'b00));

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (resp_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_comb begin
      data_addr_ok = 1'b0;
      axi.arvalid  = 1'b0;
      axi.rready   = 1'b0;
      axi.awvalid  = 1'b0;
      axi.wvalid   = 1'b0;
      axi.bready   = 1'b0;
      unique case (state_q)
         // The idle cycle that carries data_ok never accepts a new request.
         StIdle: data_addr_ok = data_req & ~data_ok_q;
         StRdA:  axi.arvalid  = 1'b1;
         StRdD:  axi.rready   = 1'b1;
         StWrAw: begin
            axi.awvalid = ~aw_done_q;
            axi.wvalid  = ~w_done_q;
         end
         StWrB:  axi.bready   = 1'b1;
         default: ;
      endcase
   end

   assign data_rdata   = rdata_q;
   assign data_data_ok = data_ok_q;
   assign err_cnt      = err_cnt_q;

   assign axi.arid    = AXI_ID;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = 8'd0;
   assign axi.arsize  = {1'b0, size_q};
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;
   assign axi.awid    = AXI_ID;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = 8'd0;
   assign axi.awsize  = {1'b0, size_q};
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'd0;
   assign axi.awprot  = 3'd0;
   assign axi.wid     = AXI_ID;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wlast   = 1'b1;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed self-checking bench for dcache_axi_bridge; inputs change at posedge+1, outputs sampled
// at negedge. Expected timings follow the WRITE_EARLY_ACK_EN setting of the build.
module tb_dcache_axi_bridge;

`ifdef WRITE_EARLY_ACK_EN
   localparam bit EarlyAck = 1'b1;
`else
   localparam bit EarlyAck = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic [31:0] data_rdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [7:0]  err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dcache_axi_bridge_if axi_bus ();

   dcache_axi_bridge #(
      .AXI_ID    (4'd1),
      .ERR_CNT_W (8)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_wstrb   (data_wstrb),
      .data_rdata   (data_rdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .axi          (axi_bus.master),
      .err_cnt      (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      data_req        = 1'b0;
      data_wr         = 1'b0;
      data_size       = 2'd0;
      data_addr       = 32'h0;
      data_wdata      = 32'h0;
      data_wstrb      = 4'h0;
      axi_bus.arready = 1'b0;
      axi_bus.rdata   = 32'h0;
      axi_bus.rresp   = 2'b00;
      axi_bus.rvalid  = 1'b0;
      axi_bus.awready = 1'b0;
      axi_bus.wready  = 1'b0;
      axi_bus.bresp   = 2'b00;
      axi_bus.bvalid  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 1'b0;
      cyc();
      cyc();
      resetn = 1'b1;
   endtask

   // Read with AR/R answered immediately: accept c0, AR c1, R c2, data_ok c3.
   task automatic run_read(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] rd, input logic [1:0] resp);
      cyc();
      data_req = 1'b1; data_wr = 1'b0; data_addr = addr; data_size = size;
      smp();
      check({tag, "_addr_ok"}, 32'(data_addr_ok), 32'd1);
      cyc();
      data_req = 1'b0; axi_bus.arready = 1'b1;
      smp();
      check({tag, "_arvalid"}, 32'(axi_bus.arvalid), 32'd1);
      check({tag, "_araddr"}, axi_bus.araddr, addr);
      check({tag, "_arsize"}, 32'(axi_bus.arsize), {29'd0, 1'b0, size});
      cyc();
      axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b1; axi_bus.rdata = rd; axi_bus.rresp = resp;
      smp();
      check({tag, "_rready"}, 32'(axi_bus.rready), 32'd1);
      check({tag, "_no_early_ok"}, 32'(data_data_ok), 32'd0);
      cyc();
      axi_bus.rvalid = 1'b0;
      smp();
      check({tag, "_data_ok"}, 32'(data_data_ok), 32'd1);
      check({tag, "_rdata"}, data_rdata, rd);
      cyc();
      smp();
      check({tag, "_ok_once"}, 32'(data_data_ok), 32'd0);
   endtask

   initial begin
      int acc, oks, acc_cyc0, acc_cyc1, first_ok, err_mid;
      logic [31:0] aw_seen [2];
      logic [31:0] w_seen [2];
      int n_aw, n_w;

      do_reset();
      data_req = 1'b1;
      smp();
      check("rst_data_ok", 32'(data_data_ok), 32'd0);
      check("rst_arvalid", 32'(axi_bus.arvalid), 32'd0);
      check("rst_awvalid", 32'(axi_bus.awvalid), 32'd0);
      check("rst_wvalid", 32'(axi_bus.wvalid), 32'd0);
      check("rst_rready", 32'(axi_bus.rready), 32'd0);
      check("rst_bready", 32'(axi_bus.bready), 32'd0);
      check("rst_rdata", data_rdata, 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_idle_accepts", 32'(data_addr_ok), 32'd1);
      check("tie_wlast", 32'(axi_bus.wlast), 32'd1);
      check("tie_arid", 32'(axi_bus.arid), 32'd1);
      cyc();
      data_req = 1'b0;
      do_reset();

      // T1 read
      run_read("t1", 32'h1FC0_0010, 2'd2, 32'hDEAD_BEEF, 2'b00);

      // T2 write, AW accepted two cycles before W
      cyc();
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0004; data_size = 2'd1;
      data_wdata = 32'h1234_5678; data_wstrb = 4'b0011;
      smp();
      check("t2_addr_ok", 32'(data_addr_ok), 32'd1);
      cyc();
      data_req = 1'b0; axi_bus.awready = 1'b1;
      smp();
      check("t2_awvalid", 32'(axi_bus.awvalid), 32'd1);
      check("t2_wvalid", 32'(axi_bus.wvalid), 32'd1);
      check("t2_awaddr", axi_bus.awaddr, 32'h8000_0004);
      check("t2_awsize", 32'(axi_bus.awsize), 32'd1);
      check("t2_wdata", axi_bus.wdata, 32'h1234_5678);
      check("t2_wstrb", 32'(axi_bus.wstrb), 32'h3);
      cyc();
      axi_bus.awready = 1'b0;
      smp();
      check("t2_aw_dropped", 32'(axi_bus.awvalid), 32'd0);
      check("t2_w_held", 32'(axi_bus.wvalid), 32'd1);
      cyc();
      axi_bus.wready = 1'b1;
      smp();
      check("t2_w_held2", 32'(axi_bus.wvalid), 32'd1);
      check("t2_wdata_stable", axi_bus.wdata, 32'h1234_5678);
      cyc();
      axi_bus.wready = 1'b0;
      smp();
      check("t2_bready", 32'(axi_bus.bready), 32'd1);
      check("t2_w_dropped", 32'(axi_bus.wvalid), 32'd0);
      check("t2_ok_on_wr_b", 32'(data_data_ok), 32'(EarlyAck));
      cyc();
      axi_bus.bvalid = 1'b1;
      smp();
      check("t2_ok_before_b", 32'(data_data_ok), 32'd0);
      cyc();
      axi_bus.bvalid = 1'b0;
      smp();
      check("t2_ok_after_b", 32'(data_data_ok), 32'(!EarlyAck));
      cyc();
      smp();
      check("t2_ok_once", 32'(data_data_ok), 32'd0);

      // T3 back-to-back writes with req held and all ready/valid high
      acc = 0; oks = 0; acc_cyc0 = -1; acc_cyc1 = -1; n_aw = 0; n_w = 0;
      cyc();
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
      data_addr = 32'h0000_0100; data_wdata = 32'hAAAA_0001;
      axi_bus.awready = 1'b1; axi_bus.wready = 1'b1; axi_bus.bvalid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         smp();
         if (data_data_ok) oks++;
         if (axi_bus.awvalid && axi_bus.awready && n_aw < 2) begin
            aw_seen[n_aw] = axi_bus.awaddr;
            n_aw++;
         end
         if (axi_bus.wvalid && axi_bus.wready && n_w < 2) begin
            w_seen[n_w] = axi_bus.wdata;
            n_w++;
         end
         if (data_addr_ok) begin
            if (acc == 0) acc_cyc0 = k;
            else if (acc == 1) acc_cyc1 = k;
            acc++;
         end
         cyc();
         if (acc == 1) begin
            data_addr = 32'h0000_0200; data_wdata = 32'hBBBB_0002;
         end else if (acc >= 2) begin
            data_req = 1'b0;
         end
      end
      idle_inputs();
      check("t3_acc0_cycle", 32'(acc_cyc0), 32'd0);
      check("t3_acc1_cycle", 32'(acc_cyc1), EarlyAck ? 32'd3 : 32'd4);
      check("t3_acc_count", 32'(acc), 32'd2);
      check("t3_ok_count", 32'(oks), 32'd2);
      check("t3_aw_count", 32'(n_aw), 32'd2);
      check("t3_aw0", aw_seen[0], 32'h0000_0100);
      check("t3_aw1", aw_seen[1], 32'h0000_0200);
      check("t3_w0", w_seen[0], 32'hAAAA_0001);
      check("t3_w1", w_seen[1], 32'hBBBB_0002);

      // T4 error counter saturation over 300 SLVERR reads
      check("t4_err_start", 32'(err_cnt), 32'd0);
      acc = 0; oks = 0; err_mid = -1;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000; data_size = 2'd2;
      axi_bus.arready = 1'b1; axi_bus.rvalid = 1'b1; axi_bus.rresp = 2'b10;
      axi_bus.rdata = 32'h0BAD_0BAD;
      for (int k = 0; k < 1500 && oks < 300; k++) begin
         smp();
         if (data_addr_ok) acc++;
         if (data_data_ok) begin
            oks++;
            if (oks == 100) err_mid = int'(err_cnt);
         end
         cyc();
         if (acc >= 300) data_req = 1'b0;
      end
      idle_inputs();
      check("t4_err_at_100", 32'(err_mid), 32'd100);
      check("t4_ok_count", 32'(oks), 32'd300);
      check("t4_acc_count", 32'(acc), 32'd300);
      check("t4_err_sat", 32'(err_cnt), 32'd255);
      check("t4_last_rdata", data_rdata, 32'h0BAD_0BAD);

      // T5 reset while in RD_D with rvalid pending
      cyc();
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000; data_size = 2'd2;
      smp();
      cyc();
      data_req = 1'b0; axi_bus.arready = 1'b1;
      smp();
      cyc();
      axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'hCAFE_F00D;
      axi_bus.rresp = 2'b10; resetn = 1'b0;
      smp();
      check("t5_in_rd_d", 32'(axi_bus.rready), 32'd1);
      cyc();
      resetn = 1'b1; axi_bus.rvalid = 1'b0; axi_bus.rresp = 2'b00;
      smp();
      check("t5_no_ok", 32'(data_data_ok), 32'd0);
      check("t5_rready", 32'(axi_bus.rready), 32'd0);
      check("t5_arvalid", 32'(axi_bus.arvalid), 32'd0);
      check("t5_rdata", data_rdata, 32'd0);
      check("t5_err_cnt", 32'(err_cnt), 32'd0);
      cyc();
      smp();
      check("t5_no_late_ok", 32'(data_data_ok), 32'd0);
      run_read("t5_fresh", 32'h0000_3000, 2'd2, 32'hA5A5_0F0F, 2'b00);

      // T6 write with B delayed five cycles, second request held pending
      first_ok = -1; acc_cyc1 = -1; oks = 0;
      cyc();
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_4000; data_size = 2'd2;
      data_wdata = 32'h6666_0006; data_wstrb = 4'hF;
      axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         smp();
         if (data_data_ok) begin
            oks++;
            if (first_ok < 0) first_ok = k;
         end
         if (k > 0 && data_addr_ok && acc_cyc1 < 0) acc_cyc1 = k;
         cyc();
         data_req = (k + 1 != 1);
         data_addr = 32'h0000_5000;
         axi_bus.bvalid = (k + 1 == 7);
      end
      check("t6_ok_cycle", 32'(first_ok), EarlyAck ? 32'd2 : 32'd8);
      check("t6_next_accept", 32'(acc_cyc1), EarlyAck ? 32'd8 : 32'd9);
      check("t6_ok_count", 32'(oks), 32'd1);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
